// File: rtl/load_store_unit.sv
// Load/store unit: word and byte accesses to a 16-bit data memory.
// Byte stores use a read-modify-write sequence; misaligned word ops error out.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wd,
  input  logic [15:0]       mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_SB = 2'b11;

  state_t state, state_nx;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              lane_q;
  logic [7:0]        byte_q;
  logic [15:0]       wd_q;

  logic [15:0] data_nx;
  logic        err_nx;
  logic [15:0] wd_nx;
  logic        accept;
  logic        misal;
  logic [7:0]  rd_byte;

  assign rd_byte = lane_q ? mem_rd[15:8] : mem_rd[7:0];
  // Only word ops care about alignment; byte ops use bit 0 as the lane.
  assign misal   = req_addr[0] & ~req_op[1];

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wd    = 16'h0000;
    data_nx   = rsp_data;
    err_nx    = rsp_err;
    wd_nx     = wd_q;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        mem_addr  = req_addr[ADDR_W:1];
        req_ready = ~rst;
        if (req_valid && !rst) begin
          accept  = 1'b1;
          data_nx = 16'h0000;
          err_nx  = misal;
          if (misal) begin
            state_nx = RESP;
          end else if (req_op == OP_SW) begin
            mem_we   = 1'b1;
            mem_wd   = req_wdata;
            state_nx = RESP;
          end else begin
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (op_q == OP_SB) begin
          wd_nx    = lane_q ? {byte_q, mem_rd[7:0]}
                            : {mem_rd[15:8], byte_q};
          state_nx = RMW_WR;
        end else begin
          data_nx  = (op_q == OP_LW) ? mem_rd
                                     : {{8{rd_byte[7]}}, rd_byte};
          state_nx = RESP;
        end
      end
      RMW_WR: begin
        mem_we   = ~rst;
        mem_wd   = rst ? 16'h0000 : wd_q;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rsp_data <= 16'h0000;
      rsp_err  <= 1'b0;
      wd_q     <= 16'h0000;
      op_q     <= 2'b00;
      addr_q   <= '0;
      lane_q   <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      state    <= state_nx;
      rsp_data <= data_nx;
      rsp_err  <= err_nx;
      wd_q     <= wd_nx;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr[ADDR_W:1];
        lane_q <= req_addr[0];
        byte_q <= req_wdata[7:0];
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the data-memory word-address width; the byte address is ADDR_W+1 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request; a transfer occurs when req_valid and req_ready are both 1.
REQ-006 The block SHALL have port req_op, input, 2 bits: 00 LW, 01 SW, 10 LB, 11 SB.
REQ-007 The block SHALL have port req_addr, input, ADDR_W+1 bits: the byte address; bit 0 selects the byte lane (0 selects [7:0], 1 selects [15:8]).
REQ-008 The block SHALL have port req_wdata, input, 16 bits: store data; SB uses bits [7:0] only.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: the response is present.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 The block SHALL have port rsp_data, output, 16 bits: load result; 0 for stores and errors.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W bits: the data-memory word address.
REQ-014 The block SHALL have port mem_we, output, 1 bit: the data-memory write enable.
REQ-015 The block SHALL have port mem_wd, output, 16 bits: the data-memory write data.
REQ-016 The block SHALL have port mem_rd, input, 16 bits: the data-memory read data; it is registered and valid in the cycle after the address is presented.

Function
REQ-017 The block SHALL implement the FSM states IDLE, RD_WAIT, RMW_WR and RESP, with at most one request outstanding.
REQ-018 req_ready SHALL be 1 only in IDLE with rst low.
REQ-019 In IDLE, mem_addr SHALL equal req_addr[ADDR_W:1] combinationally; in all other states it SHALL equal the registered address captured at accept.
REQ-020 On accepting LW or LB, the block SHALL drive mem_we=0 and go to RD_WAIT.
REQ-021 On accepting an aligned SW (addr[0]=0), the block SHALL drive mem_we=1 and mem_wd=req_wdata in the accept cycle, then go to RESP with rsp_data=0 and rsp_err=0.
REQ-022 On accepting SB, the block SHALL perform a read (mem_we=0), latch req_wdata[7:0] and the lane, and go to RD_WAIT.
REQ-023 On accepting LW or SW with addr[0]=1, the block SHALL not access memory (mem_we=0) and SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-024 In RD_WAIT for LW, the block SHALL register rsp_data=mem_rd and go to RESP.
REQ-025 In RD_WAIT for LB, the block SHALL register rsp_data as the selected byte sign-extended to 16 bits and go to RESP.
REQ-026 In RD_WAIT for SB, the block SHALL register merged data (mem_rd with the selected lane replaced by the store byte) and go to RMW_WR.
REQ-027 In RMW_WR, the block SHALL drive mem_we=1 and mem_wd=merged data for exactly one cycle, then go to RESP.
REQ-028 In RESP, rsp_valid SHALL be 1 and rsp_data and rsp_err SHALL be held stable until rsp_ready=1; on that cycle the block SHALL return to IDLE.
REQ-029 The block SHALL not accept a new request in the same cycle as a response handshake; the next accept is possible no earlier than the following cycle.
REQ-030 Latency, counted from the accept cycle T to the first rsp_valid, SHALL be: SW and misaligned accesses T+1; LW and LB T+2; SB T+3.
REQ-031 mem_we SHALL be 1 only in the SW accept cycle and in RMW_WR; mem_wd SHALL be 0 at all other times.
REQ-032 Address wrap-around SHALL not occur; every word address from 0 to 2^ADDR_W-1 SHALL be reachable, including the top word.

Reset
REQ-033 With rst high at a clock edge, the block SHALL load state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, and clear all internal registers.
REQ-034 While rst is high, mem_we and req_ready SHALL be forced to 0 combinationally, so no memory write occurs in the reset cycle.
REQ-035 Reset asserted in any state SHALL abort the operation; an SB reset in RD_WAIT or RMW_WR SHALL leave the memory word unchanged, and no response SHALL be produced for it.

Verification
REQ-036 Scenario: SW addr 0x010, data 0xBEEF, then LW addr 0x010 -> mem_we=1 at mem_addr 0x08 at T; the load gives rsp_data=0xBEEF at T+2.
REQ-037 Scenario: word 0x08 = 0xBEEF, SB addr 0x011, data 0x12 -> read at T, write mem_wd=0x12EF at T+2, rsp_valid at T+3; a following LW returns 0x12EF.
REQ-038 Scenario: LB addr 0x011 on word 0x80EF -> rsp_data=0xFF80; LB addr 0x010 -> rsp_data=0xFFEF.
REQ-039 Scenario: LW addr 0x001 -> mem_we=0 and rsp_err=1, rsp_data=0 at T+1.
REQ-040 Scenario: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_err are held stable and req_ready=0 throughout.
REQ-041 Scenario: SB with rst pulsed in RMW_WR -> mem_we=0, memory unchanged, next cycle state IDLE with rsp_valid=0.
